// File: rtl/msg_router.sv
// msg_router: hunts for a sync word, parses count/ID header, and steers payload bytes to per-ID collectors.
// Optional inter-byte idle timeout is enabled by defining MSG_ROUTER_TIMEOUT_EN.
module msg_router #(
    parameter int unsigned NumDest       = 4,
    parameter logic [15:0] SyncWord      = 16'h1234,
    parameter int unsigned MaxBytes      = 64,
    parameter int unsigned TimeoutClocks = 50000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [7:0]         InByte,
    input  logic               InByteReady,
    output logic [7:0]         DataByte,
    output logic [NumDest-1:0] ClearAddr,
    output logic [NumDest-1:0] WriteByte,
    output logic [NumDest-1:0] MsgComplete,
    output logic               BadMsg,
    output logic               Busy
);
    localparam int unsigned IdW      = (NumDest > 1) ? $clog2(NumDest) : 1;
    localparam int unsigned HdrBytes = 6;

    typedef enum logic [2:0] {
        SYNC1, SYNC2, CNT_HI, CNT_LO, ID_HI, ID_LO, PAYLOAD, DISCARD
    } state_t;

    state_t             state_q;
    logic [7:0]         hi_q;
    logic [15:0]        count_q;
    logic [15:0]        remain_q;
    logic [IdW-1:0]     dest_q;
    logic [NumDest-1:0] pend_q;
    logic [7:0]         data_q;
    logic [NumDest-1:0] clear_q;
    logic [NumDest-1:0] write_q;
    logic [NumDest-1:0] done_q;
    logic               bad_q;
    logic               busy_q;
    logic [15:0]        word_c;

`ifdef MSG_ROUTER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutClocks + 1);
    logic [TW-1:0] idle_q;
`else
    logic unused_timeout_c;
    assign unused_timeout_c = |32'(TimeoutClocks);
`endif

    assign word_c = {hi_q, InByte};

    function automatic logic [NumDest-1:0] onehot(input logic [IdW-1:0] idx);
        logic [NumDest-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Parser FSM; every strobe is a registered single-cycle pulse.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= SYNC1;
            hi_q     <= '0;
            count_q  <= '0;
            remain_q <= '0;
            dest_q   <= '0;
            pend_q   <= '0;
            data_q   <= '0;
            clear_q  <= '0;
            write_q  <= '0;
            done_q   <= '0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef MSG_ROUTER_TIMEOUT_EN
            idle_q   <= '0;
`endif
        end else begin
            clear_q <= '0;
            write_q <= '0;
            bad_q   <= 1'b0;
            done_q  <= pend_q;
            pend_q  <= '0;
`ifdef MSG_ROUTER_TIMEOUT_EN
            idle_q  <= InByteReady ? '0 : (busy_q ? idle_q + TW'(1) : '0);
`endif
            if (InByteReady) begin
                data_q <= InByte;
                case (state_q)
                    SYNC1: begin
                        if (InByte == SyncWord[15:8]) begin
                            state_q <= SYNC2;
                            busy_q  <= 1'b1;
                        end
                    end
                    SYNC2: begin
                        if (InByte == SyncWord[7:0]) begin
                            state_q <= CNT_HI;
                        end else if (InByte != SyncWord[15:8]) begin
                            state_q <= SYNC1;
                            busy_q  <= 1'b0;
                        end
                    end
                    CNT_HI: begin
                        hi_q    <= InByte;
                        state_q <= CNT_LO;
                    end
                    CNT_LO: begin
                        count_q <= word_c;
                        if (word_c < 16'(HdrBytes) || word_c > 16'(MaxBytes)) begin
                            bad_q   <= 1'b1;
                            state_q <= SYNC1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ID_HI;
                        end
                    end
                    ID_HI: begin
                        hi_q    <= InByte;
                        state_q <= ID_LO;
                    end
                    ID_LO: begin
                        remain_q <= count_q - 16'(HdrBytes);
                        if (word_c >= 16'(NumDest)) begin
                            bad_q <= 1'b1;
                            if (count_q == 16'(HdrBytes)) begin
                                state_q <= SYNC1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= DISCARD;
                            end
                        end else begin
                            dest_q  <= IdW'(word_c);
                            clear_q <= onehot(IdW'(word_c));
                            if (count_q == 16'(HdrBytes)) begin
                                pend_q  <= onehot(IdW'(word_c));
                                state_q <= SYNC1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= PAYLOAD;
                            end
                        end
                    end
                    PAYLOAD: begin
                        write_q  <= onehot(dest_q);
                        remain_q <= remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            pend_q  <= onehot(dest_q);
                            state_q <= SYNC1;
                            busy_q  <= 1'b0;
                        end
                    end
                    DISCARD: begin
                        remain_q <= remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            state_q <= SYNC1;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= SYNC1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
`ifdef MSG_ROUTER_TIMEOUT_EN
            // Idle abort: no MsgComplete is ever owed here since pend_q only lives in SYNC1.
            else if (busy_q && idle_q == TW'(TimeoutClocks - 1)) begin
                bad_q   <= 1'b1;
                state_q <= SYNC1;
                busy_q  <= 1'b0;
                idle_q  <= '0;
            end
`endif
        end
    end

    assign DataByte    = data_q;
    assign ClearAddr   = clear_q;
    assign WriteByte   = write_q;
    assign MsgComplete = done_q;
    assign BadMsg      = bad_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_msg_router.sv
// Directed bench for msg_router: frame-level model schedules expected pulses per cycle; compare runs every negedge.
module tb_msg_router;
    localparam int unsigned ND     = 4;
    localparam int          MaxCyc = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_byte = '0;
    logic       in_rdy = 1'b0;
    logic [7:0] DataByte;
    logic [3:0] ClearAddr, WriteByte, MsgComplete;
    logic       BadMsg, Busy;

    msg_router #(.NumDest(ND), .SyncWord(16'h1234), .MaxBytes(64), .TimeoutClocks(100)) dut (
        .Clock(clk), .Reset(rst), .InByte(in_byte), .InByteReady(in_rdy),
        .DataByte(DataByte), .ClearAddr(ClearAddr), .WriteByte(WriteByte),
        .MsgComplete(MsgComplete), .BadMsg(BadMsg), .Busy(Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int last_t = 0;
    int n_clr, n_wr, n_done, n_bad;

    logic [3:0] exp_clr [MaxCyc];
    logic [3:0] exp_wr  [MaxCyc];
    logic [3:0] exp_done[MaxCyc];
    logic       exp_bad [MaxCyc];
    logic [7:0] exp_data[MaxCyc];
    logic [7:0] pl[$];
    logic [7:0] wr_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the scheduled expectations, plus pulse tallies.
    always @(negedge clk) begin
        if (chk_en && cyc < MaxCyc) begin
            check("ClearAddr", 32'(ClearAddr), 32'(exp_clr[cyc]));
            check("WriteByte", 32'(WriteByte), 32'(exp_wr[cyc]));
            check("MsgComplete", 32'(MsgComplete), 32'(exp_done[cyc]));
            check("BadMsg", 32'(BadMsg), 32'(exp_bad[cyc]));
            if (exp_wr[cyc] != 4'd0) check("DataByte", 32'(DataByte), 32'(exp_data[cyc]));
            if (ClearAddr != 4'd0) n_clr++;
            if (WriteByte != 4'd0) begin
                n_wr++;
                wr_log.push_back(DataByte);
            end
            if (MsgComplete != 4'd0) n_done++;
            if (BadMsg) n_bad++;
        end
    end

    function automatic logic [3:0] oh(input int id);
        return 4'(1 << id);
    endfunction

    task automatic drive(input logic [7:0] b, output int t);
        in_byte = b;
        in_rdy  = 1'b1;
        t       = cyc;
        @(posedge clk);
        #1;
        in_rdy  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_tally();
        n_clr = 0; n_wr = 0; n_done = 0; n_bad = 0;
        wr_log.delete();
    endtask

    // Sends one framed message and schedules what the protocol says must come out.
    // n_send < 0 sends the whole payload; otherwise stops after n_send payload bytes.
    task automatic send_frame(input int count, input int id, input int n_send);
        int t;
        int rem;
        drive(8'h12, t);
        drive(8'h34, t);
        drive(8'(count >> 8), t);
        drive(8'(count), t);
        last_t = t;
        if (count < 6 || count > 64) begin
            exp_bad[t+1] = 1'b1;
            return;
        end
        drive(8'(id >> 8), t);
        drive(8'(id), t);
        last_t = t;
        rem = count - 6;
        if (id >= int'(ND)) begin
            exp_bad[t+1] = 1'b1;
            for (int i = 0; i < rem; i++) drive(8'(8'h40 + i), t);
            return;
        end
        exp_clr[t+1] = oh(id);
        if (rem == 0) begin
            exp_done[t+2] = oh(id);
            return;
        end
        for (int i = 0; i < rem; i++) begin
            if (n_send >= 0 && i >= n_send) return;
            drive(pl[i], t);
            exp_wr[t+1]   = oh(id);
            exp_data[t+1] = pl[i];
            last_t = t;
        end
        exp_done[last_t+2] = oh(id);
    endtask

    initial begin
        int t;
        for (int i = 0; i < MaxCyc; i++) begin
            exp_clr[i] = '0; exp_wr[i] = '0; exp_done[i] = '0; exp_bad[i] = 1'b0; exp_data[i] = '0;
        end
        clear_tally();

        #1 rst = 1'b1;
        #1;
        check("reset_outputs", 32'({DataByte, ClearAddr, WriteByte, MsgComplete, BadMsg, Busy}), 32'd0);
        idle(3);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Basic four-byte payload to ID 2.
        pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_frame(10, 2, -1);
        check("busy_after_msg", 32'(Busy), 32'd0);
        idle(3);
        check("t1_clr", 32'(n_clr), 32'd1);
        check("t1_wr", 32'(n_wr), 32'd4);
        check("t1_done", 32'(n_done), 32'd1);
        check("t1_bad", 32'(n_bad), 32'd0);
        check("t1_d0", 32'(wr_log[0]), 32'hAA);
        check("t1_d3", 32'(wr_log[3]), 32'hDD);
        clear_tally();

        // Garbage, a broken sync, then overlapping sync 12 12 34.
        drive(8'h55, t); drive(8'h12, t); drive(8'h55, t); drive(8'h12, t);
        pl = '{8'h5A};
        send_frame(7, 0, -1);
        idle(3);
        check("t2_clr", 32'(n_clr), 32'd1);
        check("t2_wr", 32'(n_wr), 32'd1);
        check("t2_d0", 32'(wr_log[0]), 32'h5A);
        check("t2_done", 32'(n_done), 32'd1);
        clear_tally();

        // Unknown ID is discarded; valid message right behind it is routed.
        pl = '{8'h11, 8'h22};
        send_frame(8, 7, -1);
        pl = '{8'h99};
        send_frame(7, 1, -1);
        idle(3);
        check("t3_bad", 32'(n_bad), 32'd1);
        check("t3_wr", 32'(n_wr), 32'd1);
        check("t3_d0", 32'(wr_log[0]), 32'h99);
        check("t3_done", 32'(n_done), 32'd1);
        clear_tally();

        // Length limits: 5 and 65 rejected, 64 accepted.
        send_frame(5, 0, -1);
        send_frame(65, 0, -1);
        idle(2);
        check("t4_bad", 32'(n_bad), 32'd2);
        check("t4_clr", 32'(n_clr), 32'd0);
        pl.delete();
        for (int i = 0; i < 58; i++) pl.push_back(8'(i * 3 + 1));
        send_frame(64, 3, -1);
        idle(3);
        check("t4_wr64", 32'(n_wr), 32'd58);
        check("t4_done64", 32'(n_done), 32'd1);
        clear_tally();

        // Zero payload; next frame's first byte lands in the MsgComplete cycle.
        send_frame(6, 1, -1);
        idle(1);
        pl = '{8'h77};
        send_frame(7, 3, -1);
        idle(3);
        check("t5_clr", 32'(n_clr), 32'd2);
        check("t5_wr", 32'(n_wr), 32'd1);
        check("t5_done", 32'(n_done), 32'd2);
        clear_tally();

        // Reset in the middle of a payload.
        pl = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(10, 3, 3);
        check("t6_wr_live", 32'(WriteByte), 32'h8);
        check("t6_busy_live", 32'(Busy), 32'd1);
        chk_en = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("t6_reset_outputs", 32'({DataByte, ClearAddr, WriteByte, MsgComplete, BadMsg, Busy}), 32'd0);
        idle(2);
        rst = 1'b0;
        clear_tally();
        chk_en = 1'b1;
        idle(1);
        pl = '{8'hC3};
        send_frame(7, 2, -1);
        idle(3);
        check("t6_wr", 32'(n_wr), 32'd1);
        check("t6_d0", 32'(wr_log[0]), 32'hC3);
        check("t6_done", 32'(n_done), 32'd1);
        clear_tally();

`ifdef MSG_ROUTER_TIMEOUT_EN
        // Stall after the header: idle abort after 100 quiet cycles.
        send_frame(10, 1, 0);
        exp_bad[last_t + 101] = 1'b1;
        idle(110);
        check("t7_bad", 32'(n_bad), 32'd1);
        check("t7_done", 32'(n_done), 32'd0);
        check("t7_busy", 32'(Busy), 32'd0);
        clear_tally();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/msg_router.md
Name: msg_router

Overview:
- Byte-stream message parser and dispatcher between the Arduino byte receiver and the per-message payload collectors.
- Hunts for a sync word, reads a byte count and a message ID, then steers the payload bytes to the collector for that ID.
- Each collector sees a shared data byte plus its own ClearAddr and WriteByte strobes.

Parameters:
- NumDest, 4: number of destination collectors; valid message IDs are 0..NumDest-1.
- SyncWord, 16'h1234: two sync bytes, MSB sent first.
- MaxBytes, 64: largest legal total message length in bytes, header included.
- TimeoutClocks, 50000: inter-byte idle limit, used only with the optional feature.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high.
- InByte  input  8  received byte.
- InByteReady  input  1  one-cycle strobe; InByte is valid this cycle.
- DataByte  output  8  registered copy of the last accepted byte; shared by all collectors.
- ClearAddr  output  NumDest  one-hot pulse; destination must reset its byte address.
- WriteByte  output  NumDest  one-hot pulse; destination must store DataByte.
- MsgComplete  output  NumDest  one-hot pulse; destination's payload is complete.
- BadMsg  output  1  pulse on illegal length, unknown ID or timeout.
- Busy  output  1  high in every state except SYNC1.

Behaviour:
- Interface: one clock, Clock. Reset is asynchronous and active-high, port Reset.
- Reset values: all outputs 0; state SYNC1; counters 0. Reset asserted mid-message aborts the message and emits no strobes.
- Message format: Sync hi, Sync lo, Count hi, Count lo, ID hi, ID lo, payload.
  - Count is the total message length including the 6 header bytes.
  - Payload length is Count-6.
- Bytes are accepted only on InByteReady. Each accepted byte is registered into DataByte.
- States and transitions:
  - SYNC1: byte == SyncWord[15:8] -> SYNC2; otherwise stay.
  - SYNC2: byte == SyncWord[7:0] -> CNT_HI. Else, byte == SyncWord[15:8] -> stay in SYNC2 (overlap). Else -> SYNC1.
  - CNT_HI -> CNT_LO. CNT_LO then checks the 16-bit Count:
    - Count < 6 or Count > MaxBytes -> BadMsg pulse next cycle; -> SYNC1.
    - Otherwise -> ID_HI.
  - ID_HI -> ID_LO. ID_LO then checks the 16-bit ID:
    - ID >= NumDest -> DISCARD with remaining = Count-6. If remaining is 0, -> SYNC1 instead.
    - Otherwise, the cycle after the ID_LO byte: ClearAddr[ID] = 1 for one cycle; -> PAYLOAD with remaining = Count-6.
  - BadMsg for an unknown ID pulses once, one cycle after the ID_LO byte.
  - PAYLOAD: each accepted byte gives WriteByte[ID] = 1 one cycle later, with DataByte valid in that same cycle; remaining decrements. After the last byte -> SYNC1.
  - DISCARD: bytes are consumed with no strobes. Remaining reaching 0 -> SYNC1.
- MsgComplete[ID]:
  - Normal message: pulses one cycle after the final WriteByte.
  - Zero-payload message (Count == 6): ClearAddr at T+1, MsgComplete at T+2, where T is the ID_LO byte cycle; no WriteByte.
- Latency from InByteReady to WriteByte: exactly 1 cycle.
- Back-to-back InByteReady on consecutive cycles must be handled with no byte lost.
- A byte arriving in the same cycle as the MsgComplete pulse is treated as SYNC1 input.
- Never more than one bit set in any strobe vector.
- Counters are 16 bits wide; Count is validated before payload, so there is no wrap.

Optional Feature:
- Macro MSG_ROUTER_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and counts while Busy. Reaching TimeoutClocks aborts the message:
  - BadMsg pulse, -> SYNC1.
  - No MsgComplete; a partially written destination gets no further strobes.
- Undefined: no counter; the parser waits indefinitely.

Test Plan:
- 12 34 00 0A 00 02 AA BB CC DD -> ClearAddr=4'b0100 once, then WriteByte[2] four times with DataByte AA,BB,CC,DD, then MsgComplete=4'b0100 one cycle after the last write; BadMsg stays 0.
- Leading garbage 12 12 34 ... with ID 0, Count 7, payload 5A -> overlap sync accepted; ClearAddr[0], WriteByte[0] with 5A, MsgComplete[0].
- 12 34 00 08 00 07 11 22 with NumDest=4 -> BadMsg pulse, no strobes. A valid message immediately after is routed correctly.
- 12 34 00 05 / 12 34 00 41 (MaxBytes=64) -> BadMsg after CNT_LO, back to SYNC1.
- 12 34 00 06 00 01 -> ClearAddr[1] then MsgComplete[1], no WriteByte.
- Reset asserted after the 3rd payload byte of a 10-byte message -> all outputs 0 immediately; next message parses normally.
- With MSG_ROUTER_TIMEOUT_EN and TimeoutClocks=100: stop after the ID bytes -> BadMsg at idle count 100, Busy drops, no MsgComplete.
